imem_ctrl: RTL and testbench

IMEM_CTRL -- requirements
Module: imem_ctrl

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_ctrl_if.sv | 47 ++++
 rtl/imem_rr_arbiter.sv | 31 +++
 rtl/imem_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_imem_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and defaults for the byte-wide instruction memory controller.
// The loader write path exists only when IMEM_CTRL_LOADER_EN is defined.
package imem_pkg;

    localparam int IMEM_DEPTH_DEF  = 1024;
    localparam int IMEM_ADDR_W_DEF = 10;

    typedef logic [31:0] instr_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_LAST = 3'd2,
`ifdef IMEM_CTRL_LOADER_EN
        WR      = 3'd3,
`endif
        RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/imem_ctrl_if.sv
// Fetch, loader and byte-memory signals of imem_ctrl; the controller uses the
// slave modport, the surrounding core/loader/memory use the master modport.
interface imem_ctrl_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W_DEF
) ();

    logic              fetch_valid;
    logic [31:0]       fetch_addr;
    logic              fetch_ready;
    logic              fetch_rsp_valid;
    instr_t            fetch_instr;
    logic              fetch_err;

    logic              ld_valid;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_ready;
    logic              ld_done;
    logic              ld_err;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  fetch_valid, fetch_addr,
        output fetch_ready, fetch_rsp_valid, fetch_instr, fetch_err,
        input  ld_valid, ld_addr, ld_wdata,
        output ld_ready, ld_done, ld_err,
        output mem_addr, mem_re, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output fetch_valid, fetch_addr,
        input  fetch_ready, fetch_rsp_valid, fetch_instr, fetch_err,
        output ld_valid, ld_addr, ld_wdata,
        input  ld_ready, ld_done, ld_err,
        input  mem_addr, mem_re, mem_we, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/imem_rr_arbiter.sv
// Two-way round-robin arbiter between fetch (index 0) and loader (index 1).
// The last-grant bit starts at the loader so fetch wins the first tie.
module imem_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic last_ld_q;
    logic last_ld_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_ld_q ? 2'b01 : 2'b10;
        end
    end

    assign last_ld_d = accept_i ? gnt_o[1] : last_ld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_ld_q <= 1'b1;
        end else begin
            last_ld_q <= last_ld_d;
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// Serialises 32-bit instruction fetches and loader writes onto a byte-wide memory.
// Define IMEM_CTRL_LOADER_EN to build the loader write path; otherwise it is tied off.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int IMEM_DEPTH  = IMEM_DEPTH_DEF,
    parameter int IMEM_ADDR_W = IMEM_ADDR_W_DEF
) (
    input logic        clk,
    input logic        reset,
    imem_ctrl_if.slave bus
);

    localparam logic [IMEM_ADDR_W-1:0] ADDR_ONE = 1;

    if (IMEM_DEPTH != (1 << IMEM_ADDR_W)) begin : g_depth_check
        $error("IMEM_DEPTH must equal 2**IMEM_ADDR_W");
    end

    state_t                 state_q;
    logic [1:0]             cnt_q;
    logic [23:0]            shift_q;
    instr_t                 instr_q;
    logic                   rsp_valid_q;
    logic                   fetch_err_q;
    logic                   mem_re_q;
    logic [IMEM_ADDR_W-1:0] mem_addr_q;

    logic       fetch_req;
    logic       ld_req;
    logic       accept;
    logic [1:0] gnt;

`ifdef IMEM_CTRL_LOADER_EN
    logic [23:0] wdata_q;
    logic [7:0]  mem_wdata_q;
    logic        mem_we_q;
    logic        ld_done_q;
    logic        ld_err_q;
    logic        unused_bits;

    assign ld_req      = (state_q == IDLE) & bus.ld_valid;
    assign unused_bits = ^{bus.fetch_addr[31:IMEM_ADDR_W], bus.ld_addr[31:IMEM_ADDR_W]};
`else
    logic unused_bits;

    assign ld_req      = 1'b0;
    assign unused_bits = ^{bus.fetch_addr[31:IMEM_ADDR_W], bus.ld_valid,
                           bus.ld_addr, bus.ld_wdata};
`endif

    assign fetch_req = (state_q == IDLE) & bus.fetch_valid;
    assign accept    = |gnt;

    imem_rr_arbiter u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    ({ld_req, fetch_req}),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    // Strobes are registered one cycle ahead: the accept edge already drives
    // byte 0, and read data arrives one cycle behind each mem_re.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            shift_q     <= '0;
            instr_q     <= '0;
            rsp_valid_q <= 1'b0;
            fetch_err_q <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
`ifdef IMEM_CTRL_LOADER_EN
            wdata_q     <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            ld_done_q   <= 1'b0;
            ld_err_q    <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            fetch_err_q <= 1'b0;
`ifdef IMEM_CTRL_LOADER_EN
            ld_done_q   <= 1'b0;
            ld_err_q    <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (gnt[0]) begin
                        if (bus.fetch_addr[1:0] != 2'b00) begin
                            rsp_valid_q <= 1'b1;
                            fetch_err_q <= 1'b1;
                            instr_q     <= '0;
                            state_q     <= RESP;
                        end else begin
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= bus.fetch_addr[IMEM_ADDR_W-1:0];
                            cnt_q      <= 2'd0;
                            state_q    <= RD;
                        end
                    end
`ifdef IMEM_CTRL_LOADER_EN
                    else if (gnt[1]) begin
                        if (bus.ld_addr[1:0] != 2'b00) begin
                            ld_done_q <= 1'b1;
                            ld_err_q  <= 1'b1;
                            state_q   <= RESP;
                        end else begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= bus.ld_addr[IMEM_ADDR_W-1:0];
                            mem_wdata_q <= bus.ld_wdata[31:24];
                            wdata_q     <= bus.ld_wdata[23:0];
                            cnt_q       <= 2'd0;
                            state_q     <= WR;
                        end
                    end
`endif
                end
                RD: begin
                    if (cnt_q != 2'd0) begin
                        shift_q <= {shift_q[15:0], bus.mem_rdata};
                    end
                    if (cnt_q == 2'd3) begin
                        mem_re_q   <= 1'b0;
                        mem_addr_q <= '0;
                        state_q    <= RD_LAST;
                    end else begin
                        mem_addr_q <= mem_addr_q + ADDR_ONE;
                        cnt_q      <= cnt_q + 2'd1;
                    end
                end
                RD_LAST: begin
                    instr_q     <= {shift_q, bus.mem_rdata};
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
`ifdef IMEM_CTRL_LOADER_EN
                WR: begin
                    if (cnt_q == 2'd3) begin
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        ld_done_q   <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        mem_addr_q  <= mem_addr_q + ADDR_ONE;
                        mem_wdata_q <= wdata_q[23:16];
                        wdata_q     <= {wdata_q[15:0], 8'h00};
                        cnt_q       <= cnt_q + 2'd1;
                    end
                end
`endif
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.fetch_ready     = gnt[0];
    assign bus.fetch_rsp_valid = rsp_valid_q;
    assign bus.fetch_instr     = instr_q;
    assign bus.fetch_err       = fetch_err_q;

    // Memory strobes are masked by reset so an aborted transfer stops in the reset cycle.
    assign bus.mem_re   = mem_re_q & ~reset;
    assign bus.mem_addr = reset ? '0 : mem_addr_q;

`ifdef IMEM_CTRL_LOADER_EN
    assign bus.ld_ready  = gnt[1];
    assign bus.ld_done   = ld_done_q;
    assign bus.ld_err    = ld_err_q;
    assign bus.mem_we    = mem_we_q & ~reset;
    assign bus.mem_wdata = reset ? '0 : mem_wdata_q;
`else
    assign bus.ld_ready  = 1'b0;
    assign bus.ld_done   = 1'b0;
    assign bus.ld_err    = 1'b0;
    assign bus.mem_we    = 1'b0;
    assign bus.mem_wdata = '0;
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with a byte-memory model; loader scenarios run
// only when IMEM_CTRL_LOADER_EN is defined, otherwise the tie-offs are checked.
module tb_imem_ctrl;
    import imem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [7:0]    pre_data = '0;
    logic [7:0]    mem [0:DEPTH-1];

    always #5 clk = ~clk;

    imem_ctrl_if #(.ADDR_W(AW)) bus ();

    imem_ctrl #(.IMEM_DEPTH(DEPTH), .IMEM_ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Byte memory: bench pokes take priority, reads return data one cycle later.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic run_fetch(input logic [31:0] addr, input instr_t exp, input string tag);
        logic [AW-1:0] ea;
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = addr;
        #1;
        checks++;
        if (bus.fetch_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL %s_accept: fetch_ready=%b required 1", tag, bus.fetch_ready);
        end
        step();
        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = 32'hFFFF_FFF0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) step();
            #1;
            ea = addr[AW-1:0] + AW'(k);
            checks++;
            if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== ea
                || bus.fetch_rsp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s_rd_c%0d: re=%b we=%b addr=%0d rsp=%b required re=1 we=0 addr=%0d rsp=0",
                         tag, k + 1, bus.mem_re, bus.mem_we, bus.mem_addr, bus.fetch_rsp_valid, ea);
            end
        end
        step(); #1;
        checks++;
        if (bus.mem_re !== 1'b0 || bus.mem_addr !== '0 || bus.fetch_rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_c5: re=%b addr=%0d rsp=%b required 0 0 0",
                     tag, bus.mem_re, bus.mem_addr, bus.fetch_rsp_valid);
        end
        step(); #1;
        checks++;
        if (bus.fetch_rsp_valid !== 1'b1 || bus.fetch_err !== 1'b0 || bus.fetch_instr !== exp) begin
            errors++;
            $display("[TB] FAIL %s_rsp: rsp=%b err=%b instr=%h required 1 0 %h",
                     tag, bus.fetch_rsp_valid, bus.fetch_err, bus.fetch_instr, exp);
        end
        step(); #1;
        checks++;
        if (bus.fetch_rsp_valid !== 1'b0 || bus.fetch_instr !== exp) begin
            errors++;
            $display("[TB] FAIL %s_hold: rsp=%b instr=%h required 0 %h",
                     tag, bus.fetch_rsp_valid, bus.fetch_instr, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step(); #1;
        checks++;
        if (bus.fetch_rsp_valid !== 1'b0 || bus.fetch_err !== 1'b0 || bus.fetch_instr !== 32'h0
            || bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0
            || bus.ld_done !== 1'b0 || bus.ld_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: rsp=%b err=%b instr=%h re=%b we=%b addr=%0d done=%b lderr=%b required all 0",
                     bus.fetch_rsp_valid, bus.fetch_err, bus.fetch_instr, bus.mem_re, bus.mem_we,
                     bus.mem_addr, bus.ld_done, bus.ld_err);
        end
        reset = 1'b0;
        step(); #1;
        checks++;
        if (bus.fetch_ready !== 1'b0 || bus.ld_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready_idle: fetch_ready=%b ld_ready=%b required 0 0",
                     bus.fetch_ready, bus.ld_ready);
        end
    endtask

    task automatic test_fetch();
        poke(10'd4, 8'h00); poke(10'd5, 8'hF0); poke(10'd6, 8'h00); poke(10'd7, 8'h93);
        run_fetch(32'h0000_0004, 32'h00F0_0093, "fetch4");
    endtask

    task automatic test_misaligned_fetch();
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 32'h0000_0006;
        #1;
        checks++;
        if (bus.fetch_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL misfetch_accept: fetch_ready=%b required 1", bus.fetch_ready);
        end
        step();
        bus.fetch_valid = 1'b0;
        #1;
        checks++;
        if (bus.fetch_rsp_valid !== 1'b1 || bus.fetch_err !== 1'b1 || bus.fetch_instr !== 32'h0
            || bus.mem_re !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misfetch_rsp: rsp=%b err=%b instr=%h re=%b required 1 1 00000000 0",
                     bus.fetch_rsp_valid, bus.fetch_err, bus.fetch_instr, bus.mem_re);
        end
        step(); #1;
        checks++;
        if (bus.fetch_rsp_valid !== 1'b0 || bus.fetch_err !== 1'b0 || bus.mem_re !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misfetch_after: rsp=%b err=%b re=%b required 0 0 0",
                     bus.fetch_rsp_valid, bus.fetch_err, bus.mem_re);
        end
    endtask

    task automatic test_wrap();
        poke(10'd1020, 8'h12); poke(10'd1021, 8'h34); poke(10'd1022, 8'h56); poke(10'd1023, 8'h78);
        poke(10'd0, 8'h9A); poke(10'd1, 8'hBC); poke(10'd2, 8'hDE); poke(10'd3, 8'hF0);
        run_fetch(32'h0000_03FC, 32'h1234_5678, "fetch3fc");
        run_fetch(32'h0000_0400, 32'h9ABC_DEF0, "fetch400");
    endtask

`ifdef IMEM_CTRL_LOADER_EN
    task automatic test_load();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h00; exp_b[1] = 8'h50; exp_b[2] = 8'hAA; exp_b[3] = 8'h23;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0000_0018;
        bus.ld_wdata = 32'h0050_AA23;
        #1;
        checks++;
        if (bus.ld_ready !== 1'b1 || bus.fetch_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_accept: ld_ready=%b fetch_ready=%b required 1 0", bus.ld_ready, bus.fetch_ready);
        end
        step();
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'h0000_0100;
        bus.ld_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) step();
            #1;
            checks++;
            if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_addr !== AW'(24 + k)
                || bus.mem_wdata !== exp_b[k] || bus.ld_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL load_wr_c%0d: we=%b re=%b addr=%0d data=%h done=%b required 1 0 %0d %h 0",
                         k + 1, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, bus.ld_done, 24 + k, exp_b[k]);
            end
        end
        step(); #1;
        checks++;
        if (bus.ld_done !== 1'b1 || bus.ld_err !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_done: done=%b err=%b we=%b required 1 0 0", bus.ld_done, bus.ld_err, bus.mem_we);
        end
        step(); #1;
        checks++;
        if (bus.ld_done !== 1'b0) begin
            errors++; $display("[TB] FAIL load_done_pulse: done=%b required 0", bus.ld_done);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[24 + k] !== exp_b[k]) begin
                errors++; $display("[TB] FAIL load_mem%0d: got %h required %h", 24 + k, mem[24 + k], exp_b[k]);
            end
        end
        run_fetch(32'h0000_0018, 32'h0050_AA23, "refetch18");
    endtask

    task automatic test_misaligned_load();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0000_0019;
        bus.ld_wdata = 32'h1234_5678;
        #1;
        checks++;
        if (bus.ld_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL misload_accept: ld_ready=%b required 1", bus.ld_ready);
        end
        step();
        bus.ld_valid = 1'b0;
        #1;
        checks++;
        if (bus.ld_done !== 1'b1 || bus.ld_err !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misload_rsp: done=%b err=%b we=%b required 1 1 0", bus.ld_done, bus.ld_err, bus.mem_we);
        end
        step(); #1;
        checks++;
        if (bus.ld_done !== 1'b0 || bus.ld_err !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misload_after: done=%b err=%b we=%b required 0 0 0", bus.ld_done, bus.ld_err, bus.mem_we);
        end
    endtask

    task automatic test_arbitration();
        int gseq [4];
        int ng = 0;
        reset = 1'b1;
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = 32'h0000_0020;
        bus.ld_valid    = 1'b1;
        bus.ld_addr     = 32'h0000_0040;
        bus.ld_wdata    = 32'h1111_1111;
        step(); step();
        reset = 1'b0;
        #1;
        for (int c = 0; c < 80 && ng < 4; c++) begin
            if (bus.fetch_ready === 1'b1 && bus.ld_ready === 1'b1) begin
                checks++; errors++;
                $display("[TB] FAIL arb_both_ready: fetch_ready=1 ld_ready=1 required one-hot");
            end else if (bus.fetch_ready === 1'b1) begin
                gseq[ng] = 0; ng++;
            end else if (bus.ld_ready === 1'b1) begin
                gseq[ng] = 1; ng++;
            end
            if (ng < 4) begin
                step(); #1;
            end
        end
        @(posedge clk); #1;
        bus.fetch_valid = 1'b0;
        bus.ld_valid    = 1'b0;
        for (int c = 0; c < 8; c++) step();
        checks++;
        if (ng != 4) begin
            errors++; $display("[TB] FAIL arb_timeout: grants seen=%0d required 4", ng);
        end
        for (int g = 0; g < ng; g++) begin
            checks++;
            if (gseq[g] != (g % 2)) begin
                errors++; $display("[TB] FAIL arb_grant%0d: got %0d required %0d (0=fetch 1=loader)", g, gseq[g], g % 2);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        poke(10'h30, 8'hAA); poke(10'h31, 8'hAA); poke(10'h32, 8'hAA); poke(10'h33, 8'hAA);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0000_0030;
        bus.ld_wdata = 32'h1122_3344;
        #1;
        step();
        bus.ld_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0) begin
            errors++; $display("[TB] FAIL rstload_we: mem_we=%b required 0", bus.mem_we);
        end
        step();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (bus.ld_done !== 1'b0 || bus.mem_we !== 1'b0) begin
                errors++; $display("[TB] FAIL rstload_quiet_c%0d: done=%b we=%b required 0 0", c, bus.ld_done, bus.mem_we);
            end
            step();
        end
        checks++;
        if (mem[8'h30] !== 8'h11 || mem[8'h31] !== 8'hAA || mem[8'h32] !== 8'hAA || mem[8'h33] !== 8'hAA) begin
            errors++;
            $display("[TB] FAIL rstload_mem: got %h %h %h %h required 11 aa aa aa",
                     mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]);
        end
        bus.ld_valid = 1'b1;
        #1;
        checks++;
        if (bus.ld_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL rstload_ready: ld_ready=%b required 1", bus.ld_ready);
        end
        bus.ld_valid = 1'b0;
        step();
    endtask
`else
    task automatic test_loader_disabled();
        poke(10'd24, 8'h00); poke(10'd25, 8'h50); poke(10'd26, 8'hAA); poke(10'd27, 8'h23);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0000_0040;
        bus.ld_wdata = 32'hCAFE_F00D;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (bus.ld_ready !== 1'b0 || bus.ld_done !== 1'b0 || bus.ld_err !== 1'b0 || bus.mem_we !== 1'b0) begin
                errors++;
                $display("[TB] FAIL noloader_c%0d: ready=%b done=%b err=%b we=%b required 0 0 0 0",
                         c, bus.ld_ready, bus.ld_done, bus.ld_err, bus.mem_we);
            end
            step();
        end
        run_fetch(32'h0000_0018, 32'h0050_AA23, "noloader_fetch18");
        bus.ld_valid = 1'b0;
    endtask
`endif

    task automatic test_reset_clears_instr();
        run_fetch(32'h0000_0004, 32'h00F0_0093, "prereset");
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.fetch_instr !== 32'h0 || bus.fetch_rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_instr: instr=%h rsp=%b required 00000000 0", bus.fetch_instr, bus.fetch_rsp_valid);
        end
        step();
    endtask

    initial begin
        reset           = 1'b1;
        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_wdata    = '0;
        test_reset();
        test_fetch();
        test_misaligned_fetch();
        test_wrap();
`ifdef IMEM_CTRL_LOADER_EN
        test_load();
        test_misaligned_load();
        test_arbitration();
        test_reset_mid_load();
`else
        test_loader_disabled();
`endif
        test_reset_clears_instr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
